// File: rtl/simple_13_split.sv
// Recovers the missing operand of a two-bank add from (sum, known operand, select) and demuxes the pair.
// Optional feature: define SIMPLE_13_SPLIT_BORROW_EN to add out_borrow and the sticky borrow_seen flag.
module simple_13_split #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sel,
    input  logic [WIDTH-1:0] in_sum,
    input  logic [WIDTH-1:0] in_known,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sel,
    output logic [WIDTH-1:0] out_x,
    output logic [WIDTH-1:0] out_y,
    output logic [WIDTH-1:0] bank_a,
    output logic [WIDTH-1:0] bank_b,
    output logic [WIDTH-1:0] bank_c,
    output logic [WIDTH-1:0] bank_d,
`ifdef SIMPLE_13_SPLIT_BORROW_EN
    output logic             out_borrow,
    output logic             borrow_seen,
`endif
    output logic [CNT_W-1:0] done_cnt
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]       state;
    logic             cap_sel;
    logic [WIDTH-1:0] cap_sum;
    logic [WIDTH-1:0] cap_known;
    logic [WIDTH-1:0] diff;
    logic             handshake;

    // Subtraction wraps modulo 2^WIDTH, undoing an adder that dropped its carry.
    assign diff      = cap_sum - cap_known;
    assign in_ready  = (state == IDLE);
    assign handshake = (state == HOLD) && out_valid && out_ready;

    always_ff @(posedge clk) begin
        // NOTE: every register here uses <= so all updates see pre-edge values; blocking
        // assignments would let the bank write observe an already-cleared out_valid.
        if (rst) begin
            state     <= IDLE;
            cap_sel   <= 1'b0;
            cap_sum   <= '0;
            cap_known <= '0;
            out_valid <= 1'b0;
            out_sel   <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
            bank_a    <= '0;
            bank_b    <= '0;
            bank_c    <= '0;
            bank_d    <= '0;
            done_cnt  <= '0;
`ifdef SIMPLE_13_SPLIT_BORROW_EN
            out_borrow  <= 1'b0;
            borrow_seen <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        cap_sel   <= in_sel;
                        cap_sum   <= in_sum;
                        cap_known <= in_known;
                        state     <= CALC;
                    end
                end
                CALC: begin
                    out_x     <= cap_known;
                    out_y     <= diff;
                    out_sel   <= cap_sel;
                    out_valid <= 1'b1;
`ifdef SIMPLE_13_SPLIT_BORROW_EN
                    out_borrow <= (cap_known > cap_sum);
`endif
                    state     <= HOLD;
                end
                HOLD: begin
                    if (handshake) begin
                        // Only the selected bank is written; the other keeps its last pair.
                        if (out_sel) begin
                            bank_a <= out_x;
                            bank_b <= out_y;
                        end else begin
                            bank_c <= out_x;
                            bank_d <= out_y;
                        end
                        done_cnt  <= done_cnt + CNT_ONE;
                        out_valid <= 1'b0;
`ifdef SIMPLE_13_SPLIT_BORROW_EN
                        if (out_borrow) borrow_seen <= 1'b1;
`endif
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_simple_13_split.sv
// Randomized and directed bench for simple_13_split, checked against a transaction-level model.
// Build with +define+SIMPLE_13_SPLIT_BORROW_EN to also cover the borrow outputs.
module tb_simple_13_split;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;
    localparam int MASK  = (1 << WIDTH) - 1;
    localparam int CMOD  = 1 << CNT_W;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic             in_sel;
    logic [WIDTH-1:0] in_sum;
    logic [WIDTH-1:0] in_known;
    logic             out_valid;
    logic             out_ready;
    logic             out_sel;
    logic [WIDTH-1:0] out_x;
    logic [WIDTH-1:0] out_y;
    logic [WIDTH-1:0] bank_a;
    logic [WIDTH-1:0] bank_b;
    logic [WIDTH-1:0] bank_c;
    logic [WIDTH-1:0] bank_d;
    logic [CNT_W-1:0] done_cnt;
`ifdef SIMPLE_13_SPLIT_BORROW_EN
    logic             out_borrow;
    logic             borrow_seen;
`endif

    simple_13_split #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
        .in_sum(in_sum), .in_known(in_known),
        .out_valid(out_valid), .out_ready(out_ready), .out_sel(out_sel),
        .out_x(out_x), .out_y(out_y),
        .bank_a(bank_a), .bank_b(bank_b), .bank_c(bank_c), .bank_d(bank_d),
`ifdef SIMPLE_13_SPLIT_BORROW_EN
        .out_borrow(out_borrow), .borrow_seen(borrow_seen),
`endif
        .done_cnt(done_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // Reference model: last pair per bank, completed count, sticky borrow.
    int m_a, m_b, m_c, m_d, m_cnt;
    int m_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_a = 0; m_b = 0; m_c = 0; m_d = 0; m_cnt = 0; m_seen = 0;
    endtask

    task automatic check_banks(input string tag);
        check({tag, "_bank_a"}, 32'(bank_a), m_a);
        check({tag, "_bank_b"}, 32'(bank_b), m_b);
        check({tag, "_bank_c"}, 32'(bank_c), m_c);
        check({tag, "_bank_d"}, 32'(bank_d), m_d);
        check({tag, "_done_cnt"}, 32'(done_cnt), m_cnt);
`ifdef SIMPLE_13_SPLIT_BORROW_EN
        check({tag, "_borrow_seen"}, 32'(borrow_seen), m_seen);
`endif
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b0;
        model_reset();
    endtask

    // One transaction; hold = cycles of out_ready=0 in HOLD (0 means out_ready is high throughout).
    task automatic run_txn(input string tag, input int sel, input int sum, input int known, input int hold);
        int y;
        y = (sum - known) & MASK;
        in_valid  = 1'b1;
        in_sel    = sel[0];
        in_sum    = WIDTH'(sum);
        in_known  = WIDTH'(known);
        out_ready = (hold == 0);
        check({tag, "_idle_in_ready"}, 32'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_calc_in_ready"}, 32'(in_ready), 0);
        check({tag, "_calc_out_valid"}, 32'(out_valid), 0);
        check({tag, "_calc_done_cnt"}, 32'(done_cnt), m_cnt);
        @(negedge clk);
        check({tag, "_hold_out_valid"}, 32'(out_valid), 1);
        check({tag, "_hold_out_x"}, 32'(out_x), known);
        check({tag, "_hold_out_y"}, 32'(out_y), y);
        check({tag, "_hold_out_sel"}, 32'(out_sel), sel);
`ifdef SIMPLE_13_SPLIT_BORROW_EN
        check({tag, "_hold_out_borrow"}, 32'(out_borrow), (known > sum) ? 1 : 0);
`endif
        for (int i = 0; i < hold; i++) begin
            // A competing input while stalled must be ignored.
            in_valid = 1'b1;
            in_sel   = ~sel[0];
            in_sum   = WIDTH'($urandom);
            in_known = WIDTH'($urandom);
            @(negedge clk);
            check({tag, "_stall_out_valid"}, 32'(out_valid), 1);
            check({tag, "_stall_out_x"}, 32'(out_x), known);
            check({tag, "_stall_out_y"}, 32'(out_y), y);
            check({tag, "_stall_out_sel"}, 32'(out_sel), sel);
            check({tag, "_stall_in_ready"}, 32'(in_ready), 0);
            check({tag, "_stall_done_cnt"}, 32'(done_cnt), m_cnt);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        if (sel != 0) begin m_a = known; m_b = y; end
        else begin m_c = known; m_d = y; end
        m_cnt = (m_cnt + 1) % CMOD;
        if (known > sum) m_seen = 1;
        check({tag, "_post_out_valid"}, 32'(out_valid), 0);
        check({tag, "_post_in_ready"}, 32'(in_ready), 1);
        check_banks({tag, "_post"});
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; in_sel = 1'b0; in_sum = '0; in_known = '0; out_ready = 1'b0;
        model_reset();
        @(negedge clk);

        // Reset then idle.
        do_reset(2);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_out_sel", 32'(out_sel), 0);
        check("rst_out_x", 32'(out_x), 0);
        check("rst_out_y", 32'(out_y), 0);
        check("rst_in_ready", 32'(in_ready), 1);
        check_banks("rst");
`ifdef SIMPLE_13_SPLIT_BORROW_EN
        check("rst_out_borrow", 32'(out_borrow), 0);
`endif
        // out_ready high while idle must not count anything.
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        out_ready = 1'b0;
        check_banks("idle_ready");

        run_txn("ab", 1, 9, 3, 0);
        run_txn("wrap", 0, 2, 5, 0);
        run_txn("bp", 1, 4, 11, 5);
        run_txn("after_bp", 0, 15, 15, 0);
        run_txn("zero", 1, 0, 0, 1);
        run_txn("max", 0, 0, 15, 2);

        // Reset while holding a result discards it.
        do_reset(1);
        in_valid = 1'b1; in_sel = 1'b1; in_sum = WIDTH'(7); in_known = WIDTH'(1);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("mid_hold_valid", 32'(out_valid), 1);
        rst = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b0;
        check("mid_out_valid", 32'(out_valid), 0);
        check("mid_in_ready", 32'(in_ready), 1);
        check_banks("mid");

        // 256 random completions bring the counter back to zero.
        for (int n = 0; n < CMOD; n++) begin
            run_txn("rand", int'($urandom_range(0, 1)), int'($urandom_range(0, MASK)),
                    int'($urandom_range(0, MASK)), int'($urandom_range(0, 2)));
        end
        check("wrap_cnt_zero", 32'(done_cnt), 0);
        check_banks("final");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/simple_13_split.md
Name: simple_13_split

Overview:
- Inverse of the two-bank select-and-add datapath: recovers operand pairs from a sum stream.
- Each input carries a sum, one known operand and the bank select. The block computes the missing operand, demuxes the pair into bank A/B (sel=1) or bank C/D (sel=0), and presents it on a valid/ready output.
- Sits downstream of the adder path in checking and replay logic.

Parameters:
- WIDTH, 4, operand/sum width in bits.
- CNT_W, 8, width of the completed-transaction counter.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  input transaction present.
- in_ready  output  1  block can accept input.
- in_sel  input  1  bank select: 1 = A/B bank, 0 = C/D bank.
- in_sum  input  WIDTH  sum produced by the adder.
- in_known  input  WIDTH  first operand (a when sel=1, c when sel=0).
- out_valid  output  1  recovered pair available.
- out_ready  input  1  downstream accepts pair.
- out_sel  output  1  bank tag of presented pair.
- out_x  output  WIDTH  recovered first operand (= captured in_known).
- out_y  output  WIDTH  recovered second operand.
- bank_a, bank_b  output  WIDTH each  last pair delivered with sel=1.
- bank_c, bank_d  output  WIDTH each  last pair delivered with sel=0.
- done_cnt  output  CNT_W  count of completed output handshakes.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - State goes to IDLE.
  - out_valid, out_sel, out_x, out_y, all bank_* and done_cnt go to 0; in_ready=1 in the following cycle.
  - rst overrides every other input.
  - Reset in CALC or HOLD discards the in-flight transaction: no bank update, no count.
- FSM states: IDLE, CALC, HOLD.
  - IDLE: in_ready=1. On in_valid, capture in_sel, in_sum and in_known, then go to CALC. Otherwise stay.
  - CALC: in_ready=0. Compute y = (sum - known) mod 2^WIDTH (WIDTH bits, wrap, no sign). Register out_x=known, out_y=y, out_sel=sel, set out_valid=1, go to HOLD.
  - HOLD: in_ready=0, out_valid=1. out_x, out_y and out_sel stay stable until the handshake.
  - On out_valid&&out_ready, in the same edge:
    - write the pair to bank_a/bank_b if out_sel=1, else to bank_c/bank_d;
    - increment done_cnt (wraps at 2^CNT_W-1 -> 0);
    - clear out_valid;
    - go to IDLE.
- Latency: acceptance at edge N gives out_valid=1 after edge N+1. Minimum occupancy per transaction is 3 cycles (IDLE, CALC, HOLD). No back-to-back acceptance.
- Ordering: strictly one transaction in flight; the output order equals the input order.
- Inputs are ignored while in_ready=0. in_valid held high is accepted again on the next IDLE cycle.
- The bank registers of the non-selected bank are never modified.
- out_ready asserted outside HOLD has no effect.

Optional Feature:
- Macro: SIMPLE_13_SPLIT_BORROW_EN.
- Defined:
  - Adds output port out_borrow (1 bit, reset 0), registered in CALC alongside out_y and held through HOLD.
  - out_borrow=1 when in_known > in_sum (unsigned), i.e. the original addition overflowed WIDTH bits.
  - A sticky output borrow_seen is also added. It is set on any completed handshake with out_borrow=1 and is cleared only by rst.
- Not defined: neither port exists. Datapath and timing are identical.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> all outputs 0, in_ready=1, state IDLE.
- Bank A/B path: sel=1, sum=9, known=3, out_ready=1 -> out_valid 2 edges after accept, out_x=3, out_y=6, bank_a=3, bank_b=6, bank_c=bank_d=0, done_cnt=1.
- Wrap and borrow: sel=0, sum=2, known=5 -> out_y=13, bank_c=5, bank_d=13. With the macro defined, out_borrow=1 and borrow_seen=1.
- Backpressure: out_ready=0 for 5 cycles during HOLD -> out_x/out_y/out_sel stable, in_ready=0, a second in_valid is not accepted. Raise out_ready -> handshake, then the second input is accepted.
- Reset mid-op: accept sel=1, sum=7, known=1, assert rst in HOLD -> bank_a/bank_b stay 0, done_cnt=0, out_valid=0.
- Counter wrap: 256 completed transactions with CNT_W=8 -> done_cnt returns to 0 and banks hold the last pair for each select.
